lsu_port: RTL and testbench

LSU_PORT -- requirements
Module: lsu_port

---
 rtl/lsu_port.sv | 205 ++++++++++++++++++++
 tb/tb_lsu_port.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_port.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_port: single-outstanding load/store unit bridging a CPU port to a word bus
// Rev 1.0
// ----------------------------------------------------------------------------
module lsu_port #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT);

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_HS = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_BS = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [2:0]  op_q;
  logic [15:0] cnt_q, cnt_nxt, cnt_inc;
  logic [31:0] rdata_q, rdata_nxt;
  logic [1:0]  err_q, err_nxt;

  logic        accept, illegal, misaligned, timeout;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  assign accept  = (state == S_IDLE) && req_valid;
  assign illegal = (req_op > OP_BU);
  assign cnt_inc = cnt_q + 16'd1;
  assign timeout = (cnt_inc == WAIT_LIMIT);

  always_comb begin
    misaligned = 1'b0;
    case (req_op)
      OP_W:         misaligned = (req_addr[1:0] != 2'b00);
      OP_HS, OP_HU: misaligned = req_addr[0];
      default:      misaligned = 1'b0;
    endcase
  end

  // Lane selection uses the registered address; bus data is only looked at in WAIT
  always_comb begin
    lane_byte = 8'h00;
    case (addr_q[1:0])
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = 32'h0;
    case (op_q)
      OP_W:    load_data = mem_rdata;
      OP_HS:   load_data = {{16{lane_half[15]}}, lane_half};
      OP_HU:   load_data = {16'h0000, lane_half};
      OP_BS:   load_data = {{24{lane_byte[7]}}, lane_byte};
      OP_BU:   load_data = {24'h000000, lane_byte};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    rdata_nxt = rdata_q;
    err_nxt   = err_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (illegal) begin
            state_nxt = S_RESP;
            err_nxt   = ERR_ILLEGAL;
            rdata_nxt = 32'h0;
          end else if (misaligned) begin
            state_nxt = S_RESP;
            err_nxt   = ERR_ALIGN;
            rdata_nxt = 32'h0;
          end else begin
            state_nxt = S_REQ;
            cnt_nxt   = 16'h0;
          end
        end
      end
      S_REQ: begin
        cnt_nxt = cnt_inc;
        if (timeout) begin
          state_nxt = S_RESP;
          err_nxt   = ERR_TIMEOUT;
          rdata_nxt = 32'h0;
        end else if (mem_gnt) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt_inc;
        // A response arriving on the limit cycle still completes successfully
        if (mem_rvalid) begin
          state_nxt = S_RESP;
          err_nxt   = ERR_OK;
          rdata_nxt = we_q ? 32'h0 : load_data;
        end else if (timeout) begin
          state_nxt = S_RESP;
          err_nxt   = ERR_TIMEOUT;
          rdata_nxt = 32'h0;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      op_q    <= 3'd0;
      cnt_q   <= 16'h0;
      rdata_q <= 32'h0;
      err_q   <= ERR_OK;
    end else begin
      state   <= state_nxt;
      cnt_q   <= cnt_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        we_q    <= req_we;
        op_q    <= req_op;
      end
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_req    = (state == S_REQ);
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = wdata_q;
    case (op_q)
      OP_W: begin
        mem_be    = 4'b1111;
        mem_wdata = wdata_q;
      end
      OP_HS, OP_HU: begin
        mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{wdata_q[15:0]}};
      end
      OP_BS, OP_BU: begin
        mem_be    = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{wdata_q[7:0]}};
      end
      default: begin
        mem_be    = 4'b0000;
        mem_wdata = wdata_q;
      end
    endcase
    if (!mem_req) mem_be = 4'b0000;
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_port.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lsu_port: scoreboard bench for lsu_port (default and MAX_WAIT=4 instances)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_lsu_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        a_req_ready, a_resp_valid, a_mem_req, a_mem_we;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [1:0]  a_resp_err;
  logic [3:0]  a_mem_be;
  logic        b_req_ready, b_resp_valid, b_mem_req, b_mem_we;
  logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
  logic [1:0]  b_resp_err;
  logic [3:0]  b_mem_be;

  logic        req_ready_s, resp_valid_s, mem_req_s, mem_we_s;
  logic [31:0] resp_rdata_s, mem_addr_s, mem_wdata_s;
  logic [1:0]  resp_err_s;
  logic [3:0]  mem_be_s;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] rdata; logic [1:0] err; } resp_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we; } bus_t;
  resp_t resp_q[$];
  bus_t  bus_q[$];

  always #5 clk = ~clk;

  lsu_port dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .mem_req(a_mem_req), .mem_gnt(mem_gnt & ~sel), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
    .mem_rvalid(mem_rvalid & ~sel), .mem_rdata(mem_rdata)
  );

  lsu_port #(.MAX_WAIT(4)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .mem_req(b_mem_req), .mem_gnt(mem_gnt & sel), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
    .mem_rvalid(mem_rvalid & sel), .mem_rdata(mem_rdata)
  );

  assign req_ready_s  = sel ? b_req_ready  : a_req_ready;
  assign resp_valid_s = sel ? b_resp_valid : a_resp_valid;
  assign resp_rdata_s = sel ? b_resp_rdata : a_resp_rdata;
  assign resp_err_s   = sel ? b_resp_err   : a_resp_err;
  assign mem_req_s    = sel ? b_mem_req    : a_mem_req;
  assign mem_we_s     = sel ? b_mem_we     : a_mem_we;
  assign mem_addr_s   = sel ? b_mem_addr   : a_mem_addr;
  assign mem_be_s     = sel ? b_mem_be     : a_mem_be;
  assign mem_wdata_s  = sel ? b_mem_wdata  : a_mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid_s === 1'b1) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got rdata %h err %b expected no response", resp_rdata_s, resp_err_s);
        end else begin
          e = resp_q.pop_front();
          chk("resp_rdata", resp_rdata_s, e.rdata);
          chk("resp_err", 32'(resp_err_s), 32'(e.err));
        end
      end
    end
  end

  // Bus monitor: a new transaction starts at each mem_req rise; fields must stay stable
  initial begin
    bus_t cur;
    logic prev = 1'b0;
    cur = '{32'h0, 4'h0, 32'h0, 1'b0};
    forever begin
      @(negedge clk);
      if (mem_req_s === 1'b1) begin
        if (!prev) begin
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_req: got addr %h expected no bus request", mem_addr_s);
          end else begin
            cur = bus_q.pop_front();
          end
        end
        chk("mem_addr", mem_addr_s, cur.addr);
        chk("mem_be", 32'(mem_be_s), 32'(cur.be));
        chk("mem_wdata", mem_wdata_s, cur.wdata);
        chk("mem_we", 32'(mem_we_s), 32'(cur.we));
      end else begin
        chk("mem_be_idle", 32'(mem_be_s), 32'h0);
      end
      prev = mem_req_s;
    end
  end

  // gdly<0: no grant ever. Otherwise grant in cycle 1+gdly, rvalid in cycle 2+gdly+rdly.
  task automatic run(input logic use_b, input logic we, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int gdly, input int rdly, input logic [31:0] rd,
                     input logic bus, input logic [31:0] ebaddr, input logic [3:0] ebe,
                     input logic [31:0] ebwd, input logic [31:0] erd, input logic [1:0] eerr,
                     input int elat, input int ereq);
    int lat = 0;
    int nreq = 0;
    sel = use_b;
    if (bus) bus_q.push_back('{ebaddr, ebe, ebwd, we});
    resp_q.push_back('{erd, eerr});
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready_s), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      mem_gnt    = (gdly >= 0) && (c == 1 + gdly);
      mem_rvalid = (gdly >= 0) && (c == 2 + gdly + rdly);
      mem_rdata  = rd;
      @(negedge clk);
      if (mem_req_s) nreq++;
      if (resp_valid_s) begin
        lat = c;
        break;
      end
      chk("req_ready_busy", 32'(req_ready_s), 32'h0);
      @(posedge clk); #1;
    end
    chk("resp_latency", 32'(lat), 32'(elat));
    chk("mem_req_cycles", 32'(nreq), 32'(ereq));
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("resp_pulse_end", 32'(resp_valid_s), 32'h0);
    chk("resp_rdata_hold", resp_rdata_s, erd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #2;
    chk("rst_req_ready", 32'(req_ready_s), 32'h1);
    chk("rst_mem_req", 32'(mem_req_s), 32'h0);
    chk("rst_mem_we", 32'(mem_we_s), 32'h0);
    chk("rst_mem_addr", mem_addr_s, 32'h0);
    chk("rst_mem_wdata", mem_wdata_s, 32'h0);
    chk("rst_resp_valid", 32'(resp_valid_s), 32'h0);
    chk("rst_resp_rdata", resp_rdata_s, 32'h0);
    chk("rst_resp_err", 32'(resp_err_s), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // load byte signed, lane 3
    run(0, 0, 3'd3, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234,
        1, 32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 2'b00, 3, 1);
    // store half, upper lane
    run(0, 1, 3'd1, 32'h0000_0006, 32'h0000_ABCD, 0, 0, 32'hDEAD_BEEF,
        1, 32'h0000_0004, 4'b1100, 32'hABCD_ABCD, 32'h0, 2'b00, 3, 1);
    // misaligned word load, then illegal op at odd address
    run(0, 0, 3'd0, 32'h0000_0002, 32'h0, -1, 0, 32'h0,
        0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b01, 1, 0);
    run(0, 0, 3'd6, 32'h0000_0003, 32'h0, -1, 0, 32'h0,
        0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b11, 1, 0);
    // load half unsigned with grant delayed 3 cycles
    run(0, 0, 3'd2, 32'h0000_0002, 32'h1234_5678, 3, 0, 32'hF00D_0000,
        1, 32'h0000_0000, 4'b1100, 32'h5678_5678, 32'h0000_F00D, 2'b00, 6, 4);
    // load word, grant after 1 cycle
    run(0, 0, 3'd0, 32'h0000_0100, 32'hCAFE_F00D, 1, 0, 32'h89AB_CDEF,
        1, 32'h0000_0100, 4'b1111, 32'hCAFE_F00D, 32'h89AB_CDEF, 2'b00, 4, 2);
    // load byte unsigned lane 1
    run(0, 0, 3'd4, 32'h0000_2001, 32'h0000_00A5, 0, 0, 32'h1122_8344,
        1, 32'h0000_2000, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0083, 2'b00, 3, 1);
    // load half signed, upper lane
    run(0, 0, 3'd1, 32'h0000_0002, 32'h0, 0, 1, 32'h8001_7FFF,
        1, 32'h0000_0000, 4'b1100, 32'h0, 32'hFFFF_8001, 2'b00, 4, 1);

    // reset while waiting for read data: immediate reset values, no response
    sel = 1'b0;
    bus_q.push_back('{32'h0000_0080, 4'b1111, 32'h0000_0077, 1'b0});
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h0000_0080; req_wdata = 32'h0000_0077;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("wait_req_ready", 32'(req_ready_s), 32'h0);
    reset = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready_s), 32'h1);
    chk("arst_mem_req", 32'(mem_req_s), 32'h0);
    chk("arst_mem_be", 32'(mem_be_s), 32'h0);
    chk("arst_mem_addr", mem_addr_s, 32'h0);
    chk("arst_mem_wdata", mem_wdata_s, 32'h0);
    chk("arst_resp_valid", 32'(resp_valid_s), 32'h0);
    chk("arst_resp_rdata", resp_rdata_s, 32'h0);
    chk("arst_resp_err", 32'(resp_err_s), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_abort_ready", 32'(req_ready_s), 32'h1);

    // store byte lane 3 after the abort
    run(0, 1, 3'd3, 32'h0000_0003, 32'h1234_56C3, 0, 0, 32'hFFFF_FFFF,
        1, 32'h0000_0000, 4'b1000, 32'hC3C3_C3C3, 32'h0, 2'b00, 3, 1);
    // misaligned word store; illegal ops 5 and 7
    run(0, 1, 3'd0, 32'h0000_0001, 32'h1111_1111, -1, 0, 32'h0,
        0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b01, 1, 0);
    run(0, 0, 3'd5, 32'h0000_0000, 32'h0, -1, 0, 32'h0,
        0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b11, 1, 0);
    run(0, 0, 3'd7, 32'h0000_0002, 32'h0, -1, 0, 32'h0,
        0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b11, 1, 0);

    // MAX_WAIT=4 instance: grant never arrives
    run(1, 0, 3'd0, 32'h0000_0040, 32'h0, -1, 0, 32'h5555_5555,
        1, 32'h0000_0040, 4'b1111, 32'h0, 32'h0, 2'b10, 5, 4);
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("timeout_ready_back", 32'(req_ready_s), 32'h1);
    // rvalid on the very cycle the counter hits the limit completes normally
    run(1, 0, 3'd0, 32'h0000_0044, 32'h0, 0, 2, 32'h0BAD_CAFE,
        1, 32'h0000_0044, 4'b1111, 32'h0, 32'h0BAD_CAFE, 2'b00, 5, 1);

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", 32'(resp_q.size()), 32'h0);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
